// File: rtl/decodifica_ud_pkg.sv
// Shared types and constants for the up/down command decoder.
// Holds UD command codes, counter limits and the FSM state enum.
package decodifica_ud_pkg;

   localparam logic [1:0] UD_MANTEM = 2'b00;
   localparam logic [1:0] UD_DESCE  = 2'b01;
   localparam logic [1:0] UD_SOBE   = 2'b10;
   localparam logic [1:0] UD_CARGA  = 2'b11;

   localparam logic [3:0] VAL_MAX    = 4'd9;
   localparam logic [3:0] WRAP_DESCE = 4'd8;

   localparam logic [7:0] CONT_MAX = 8'd255;

   typedef enum logic [1:0] {
      SEM_REF = 2'b00,
      TRAVADO = 2'b01,
      ERRO    = 2'b10
   } estado_t;

endpackage

// File: rtl/decodifica_ud_classifica.sv
// Combinational classifier of a prev->cur counter sample pair.
// Produces the inferred UD code and whether the pair is legal.
module classifica_transicao
   import decodifica_ud_pkg::*;
(
   input  logic [3:0] prev,
   input  logic [3:0] cur,
   output logic [1:0] code,
   output logic       legal
);

   logic prev_ok;
   logic cur_ok;
   logic eq;
   logic carga;
   logic desce;
   logic desce_wrap;
   logic sobe;
   logic sobe_wrap;

   always_comb begin
      prev_ok    = (prev <= VAL_MAX);
      cur_ok     = (cur <= VAL_MAX);
      eq         = prev_ok && cur_ok && (prev == cur);
      carga      = (cur == VAL_MAX) && (prev < VAL_MAX);
      desce      = (prev >= 4'd1) && (prev <= WRAP_DESCE)
                   && (cur == prev - 4'd1);
      desce_wrap = ((prev == 4'd0) || (prev == VAL_MAX))
                   && (cur == WRAP_DESCE);
      sobe       = (prev < WRAP_DESCE) && (cur == prev + 4'd1);
      sobe_wrap  = ((prev == WRAP_DESCE) || (prev == VAL_MAX))
                   && (cur == 4'd0);
   end

   // The match terms are mutually exclusive by construction.
   always_comb begin
      code  = UD_MANTEM;
      legal = 1'b0;
      unique case (1'b1)
         eq: begin
            code  = UD_MANTEM;
            legal = 1'b1;
         end
         carga: begin
            code  = UD_CARGA;
            legal = 1'b1;
         end
         desce, desce_wrap: begin
            code  = UD_DESCE;
            legal = 1'b1;
         end
         sobe, sobe_wrap: begin
            code  = UD_SOBE;
            legal = 1'b1;
         end
         default: begin
            code  = UD_MANTEM;
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/decodifica_ud.sv
// Infers the UD command applied to a 0..9 up/down counter from
// sampled counter states, with lock/recovery FSM and error count.
module decodifica_ud
   import decodifica_ud_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       amostra,
   input  logic [3:0] estado_in,
   input  logic       limpa,
   output logic [1:0] ud_out,
   output logic       ud_valido,
   output logic       erro,
   output logic       travado,
   output logic [7:0] cont_erros
);

   estado_t    state_q, state_d;
   logic [3:0] prev_q, prev_d;
   logic       run_q, run_d;
   logic [1:0] ud_q, ud_d;
   logic       valido_q, valido_d;
   logic       erro_q, erro_d;
   logic       travado_q, travado_d;
   logic [7:0] cont_q, cont_d;

   logic [1:0] code;
   logic       legal;
   logic       inc;

   classifica_transicao u_classifica (
      .prev  (prev_q),
      .cur   (estado_in),
      .code  (code),
      .legal (legal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= SEM_REF;
         prev_q    <= 4'd0;
         run_q     <= 1'b0;
         ud_q      <= UD_MANTEM;
         valido_q  <= 1'b0;
         erro_q    <= 1'b0;
         travado_q <= 1'b0;
         cont_q    <= 8'd0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         run_q     <= run_d;
         ud_q      <= ud_d;
         valido_q  <= valido_d;
         erro_q    <= erro_d;
         travado_q <= travado_d;
         cont_q    <= cont_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      prev_d   = prev_q;
      run_d    = run_q;
      ud_d     = ud_q;
      valido_d = 1'b0;
      erro_d   = 1'b0;
      inc      = 1'b0;
      if (amostra) begin
         if (estado_in > VAL_MAX) begin
            erro_d  = 1'b1;
            inc     = 1'b1;
            prev_d  = 4'd0;
            run_d   = 1'b0;
            state_d = SEM_REF;
         end else begin
            prev_d = estado_in;
            unique case (state_q)
               SEM_REF: begin
                  run_d   = 1'b0;
                  state_d = TRAVADO;
               end
               TRAVADO: begin
                  if (legal) begin
                     ud_d     = code;
                     valido_d = 1'b1;
                  end else begin
                     erro_d  = 1'b1;
                     inc     = 1'b1;
                     run_d   = 1'b0;
                     state_d = ERRO;
                  end
               end
               ERRO: begin
                  // run_q marks one legal pair already seen.
                  if (!legal) begin
                     erro_d = 1'b1;
                     inc    = 1'b1;
                     run_d  = 1'b0;
                  end else if (run_q) begin
                     run_d   = 1'b0;
                     state_d = TRAVADO;
                  end else begin
                     run_d = 1'b1;
                  end
               end
               default: begin
                  run_d   = 1'b0;
                  state_d = SEM_REF;
               end
            endcase
         end
      end
      travado_d = (state_d == TRAVADO);
   end

   always_comb begin
      cont_d = cont_q;
      if (limpa) begin
         cont_d = 8'd0;
      end else if (inc && (cont_q != CONT_MAX)) begin
         cont_d = cont_q + 8'd1;
      end
   end

   assign ud_out     = ud_q;
   assign ud_valido  = valido_q;
   assign erro       = erro_q;
   assign travado    = travado_q;
   assign cont_erros = cont_q;

endmodule

// File: tb/tb_decodifica_ud.sv
// Directed self-checking bench for decodifica_ud.
module tb_decodifica_ud;

   logic       clk;
   logic       rst_n;
   logic       amostra;
   logic [3:0] estado_in;
   logic       limpa;
   logic [1:0] ud_out;
   logic       ud_valido;
   logic       erro;
   logic       travado;
   logic [7:0] cont_erros;

   int n_chk;
   int n_fail;

   decodifica_ud dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .amostra    (amostra),
      .estado_in  (estado_in),
      .limpa      (limpa),
      .ud_out     (ud_out),
      .ud_valido  (ud_valido),
      .erro       (erro),
      .travado    (travado),
      .cont_erros (cont_erros)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one sample at the next rising edge, return #1 after it.
   task automatic amostrar(input logic [3:0] v, input logic lp);
      @(negedge clk);
      amostra   = 1'b1;
      estado_in = v;
      limpa     = lp;
      @(posedge clk);
      #1;
      amostra = 1'b0;
      limpa   = 1'b0;
   endtask

   task automatic ocioso(input logic [3:0] v);
      @(negedge clk);
      amostra   = 1'b0;
      estado_in = v;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic chk_pulso(input string tag, input logic v,
                            input logic e, input logic t);
      chk({tag, "_valido"}, {7'd0, ud_valido}, {7'd0, v});
      chk({tag, "_erro"}, {7'd0, erro}, {7'd0, e});
      chk({tag, "_travado"}, {7'd0, travado}, {7'd0, t});
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      amostra   = 1'b0;
      estado_in = 4'd0;
      limpa     = 1'b0;
      #2;
      chk("rst_ud", {6'd0, ud_out}, 8'd0);
      chk_pulso("rst", 1'b0, 1'b0, 1'b0);
      chk("rst_cont", cont_erros, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 3,4,5,4,4,9
      amostrar(4'd3, 1'b0);
      chk_pulso("s3", 1'b0, 1'b0, 1'b1);
      amostrar(4'd4, 1'b0);
      chk_pulso("s4", 1'b1, 1'b0, 1'b1);
      chk("s4_ud", {6'd0, ud_out}, 8'd2);
      amostrar(4'd5, 1'b0);
      chk("s5_ud", {6'd0, ud_out}, 8'd2);
      amostrar(4'd4, 1'b0);
      chk("s54_ud", {6'd0, ud_out}, 8'd1);
      amostrar(4'd4, 1'b0);
      chk("s44_ud", {6'd0, ud_out}, 8'd0);
      chk_pulso("s44", 1'b1, 1'b0, 1'b1);
      amostrar(4'd9, 1'b0);
      chk("s9_ud", {6'd0, ud_out}, 8'd3);
      ocioso(4'd15);
      chk_pulso("idle", 1'b0, 1'b0, 1'b1);
      chk("idle_ud", {6'd0, ud_out}, 8'd3);
      chk("idle_cont", cont_erros, 8'd0);

      // Wrap pairs
      do_reset();
      amostrar(4'd9, 1'b0);
      amostrar(4'd0, 1'b0);
      chk("w90_ud", {6'd0, ud_out}, 8'd2);
      chk("w90_v", {7'd0, ud_valido}, 8'd1);
      do_reset();
      amostrar(4'd9, 1'b0);
      amostrar(4'd8, 1'b0);
      chk("w98_ud", {6'd0, ud_out}, 8'd1);
      do_reset();
      amostrar(4'd0, 1'b0);
      amostrar(4'd8, 1'b0);
      chk("w08_ud", {6'd0, ud_out}, 8'd1);
      do_reset();
      amostrar(4'd8, 1'b0);
      amostrar(4'd0, 1'b0);
      chk("w80_ud", {6'd0, ud_out}, 8'd2);

      // Illegal pair then recovery
      do_reset();
      amostrar(4'd2, 1'b0);
      amostrar(4'd6, 1'b0);
      chk_pulso("e26", 1'b0, 1'b1, 1'b0);
      chk("e26_cont", cont_erros, 8'd1);
      amostrar(4'd7, 1'b0);
      chk_pulso("e7", 1'b0, 1'b0, 1'b0);
      amostrar(4'd8, 1'b0);
      chk_pulso("e8", 1'b0, 1'b0, 1'b1);
      amostrar(4'd9, 1'b0);
      chk_pulso("e9", 1'b1, 1'b0, 1'b1);
      chk("e9_ud", {6'd0, ud_out}, 8'd3);

      // Out-of-range sample while locked
      amostrar(4'd12, 1'b0);
      chk_pulso("r12", 1'b0, 1'b1, 1'b0);
      chk("r12_cont", cont_erros, 8'd2);
      amostrar(4'd5, 1'b0);
      chk_pulso("r5", 1'b0, 1'b0, 1'b1);
      chk("r5_ud", {6'd0, ud_out}, 8'd3);
      amostrar(4'd6, 1'b0);
      chk_pulso("r6", 1'b1, 1'b0, 1'b1);
      chk("r6_ud", {6'd0, ud_out}, 8'd2);

      // Saturation and clear
      do_reset();
      amostrar(4'd0, 1'b0);
      for (int i = 0; i < 300; i++) begin
         amostrar((i % 2 == 0) ? 4'd5 : 4'd0, 1'b0);
         if (i == 253) chk("sat_254", cont_erros, 8'd254);
         if (i == 254) chk("sat_255", cont_erros, 8'd255);
      end
      chk("sat_300", cont_erros, 8'd255);
      chk("sat_erro", {7'd0, erro}, 8'd1);
      amostrar(4'd5, 1'b1);
      chk("clr_erro", {7'd0, erro}, 8'd1);
      chk("clr_cont", cont_erros, 8'd0);
      amostrar(4'd0, 1'b0);
      chk("clr_inc", cont_erros, 8'd1);

      // Reset between sampling edges
      do_reset();
      amostrar(4'd3, 1'b0);
      amostrar(4'd4, 1'b0);
      chk("mr_v_pre", {7'd0, ud_valido}, 8'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_pulso("mr", 1'b0, 1'b0, 1'b0);
      chk("mr_ud", {6'd0, ud_out}, 8'd0);
      chk("mr_cont", cont_erros, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      amostrar(4'd5, 1'b0);
      chk_pulso("mr5", 1'b0, 1'b0, 1'b1);
      amostrar(4'd6, 1'b0);
      chk("mr6_ud", {6'd0, ud_out}, 8'd2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/decodifica_ud.md
DECODIFICA_UD -- requirements
Module: decodifica_ud

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 amostra  input  1  sample strobe; estado_in is sampled only at rising edges where amostra=1.
REQ-005 estado_in  input  4  observed counter state, legal range 0..9.
REQ-006 limpa  input  1  synchronous clear of cont_erros.
REQ-007 ud_out  output  2  decoded command: 00 hold, 01 down, 10 up, 11 load-9.
REQ-008 ud_valido  output  1  one-cycle pulse qualifying ud_out.
REQ-009 erro  output  1  one-cycle pulse marking an illegal sample or transition.
REQ-010 travado  output  1  high while the FSM is in TRAVADO.
REQ-011 cont_erros  output  8  saturating error count.

Function
REQ-012 The block SHALL infer, from consecutive samples prev->cur, the UD command applied to the up/down counter.
REQ-013 Decode table SHALL be as follows; any pair not listed is illegal.
- prev=cur=0..8 -> 00.
- prev=cur=9 -> 00.
- cur=9, prev 0..8 -> 11.
- prev 1..8, cur=prev-1 -> 01.
- prev in {0,9}, cur=8 -> 01.
- prev 0..7, cur=prev+1 -> 10.
- prev in {8,9}, cur=0 -> 10.
REQ-014 The FSM SHALL have states SEM_REF (no reference sample), TRAVADO (locked) and ERRO (recovering).
REQ-015 SEM_REF: a sample of 0..9 SHALL be stored as prev, emit no pulse, and move to TRAVADO.
REQ-016 TRAVADO: a legal pair SHALL drive ud_out to the decoded code, pulse ud_valido and update prev.
REQ-017 TRAVADO: an illegal pair SHALL pulse erro, increment cont_erros, update prev and move to ERRO.
REQ-018 ERRO: two consecutive legal pairs SHALL return the FSM to TRAVADO; ud_valido SHALL stay 0 in ERRO, including on the returning sample.
REQ-019 ERRO: an illegal pair SHALL pulse erro, increment cont_erros, reset the legal-pair run to 0 and update prev.
REQ-020 In any state, a sample of 10..15 SHALL pulse erro, increment cont_erros, discard prev and move to SEM_REF.
REQ-021 Latency SHALL be 1 cycle: pulses are high exactly in the cycle after the sampling edge.
REQ-022 ud_out SHALL hold its last decoded value between pulses.
REQ-023 Cycles with amostra=0 SHALL change no state, and erro and ud_valido SHALL be 0 in them.
REQ-024 cont_erros SHALL saturate at 255.
REQ-025 When limpa=1 at an edge, cont_erros SHALL become 0, and limpa SHALL override a simultaneous error increment.
REQ-026 travado SHALL be a registered output of the state.

Reset
REQ-027 rst_n=0 SHALL immediately force the state to SEM_REF, prev to 0, and the legal-pair run to 0.
REQ-028 rst_n=0 SHALL immediately force ud_out=00, ud_valido=0, erro=0, travado=0 and cont_erros=0.
REQ-029 A reset asserted mid-operation SHALL discard any pending pulse.
REQ-030 The first sample after reset SHALL only establish the reference.

Structure
REQ-031 A shared package SHALL hold:
- UD codes UD_MANTEM=00, UD_DESCE=01, UD_SOBE=10, UD_CARGA=11;
- VAL_MAX=9 and WRAP_DESCE=8;
- the FSM state enum.
REQ-032 The combinational pair classifier SHALL be a sub-module named classifica_transicao, with inputs prev and cur and outputs code and legal.
REQ-033 The top level SHALL contain only the FSM, the registers and the counter.

Verification
REQ-034 Samples 3,4,5,4,4,9 -> ud_valido pulses with ud_out 10,10,01,00,11; travado=1 from the cycle after sample 3.
REQ-035 Samples 9,0 then 9,8 (reset between the two pairs) -> ud_out 10 then 01; samples 0,8 -> 01; samples 8,0 -> 10.
REQ-036 Samples 2,6 -> erro pulse, cont_erros=1, FSM in ERRO; then 7,8 -> no ud_valido on either sample, travado=1 after sample 8.
REQ-037 A sample of 12 while locked -> erro, SEM_REF, travado=0; next sample 5 -> no pulse; then 6 -> ud_out 10.
REQ-038 300 illegal pairs -> cont_erros=255; limpa coincident with an illegal pair -> erro pulses and cont_erros=0.
REQ-039 rst_n low between sampling edges mid-sequence -> all outputs 0 immediately; the next sample produces no pulse.
